// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the multicycle MIPS control path.
//                Holds the main-decoder state encoding, the opcode values
//                the decoder recognises and the 2-bit ALU class codes that
//                the main decoder and the ALU decoder both use.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Main decoder states. Thirteen states fit in 4 bits; the three spare
  // codes are treated as illegal and recover to S_FETCH.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IWB     = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  // Opcode field instr[31:26]
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  // ALU decoder class codes
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] c_ALUOP_OR    = 2'b11;

  // ALU operand-B selects
  localparam logic [1:0] c_SRCB_REG   = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
  localparam logic [1:0] c_SRCB_IMM   = 2'b10;
  localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

  // Next-PC selects
  localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/multicycle_maindec.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_maindec
//  Description : Moore-style main decoder for a multicycle MIPS datapath.
//                Steps through fetch / decode / execute / memory / writeback
//                states and drives the datapath enables and mux selects
//                from the current state only.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                op[5:0]           - opcode from the instruction register
//                alu_op[1:0]       - class code to the ALU decoder
//                alu_src_a         - 0 = PC, 1 = register A
//                alu_src_b[1:0]    - B / 4 / ext imm / imm<<2
//                zero_ext          - 1 = zero-extend immediate
//                pc_src[1:0]       - ALU result / ALUOut / jump target
//                iord              - memory address select (1 = ALUOut)
//                ir_write, pc_write, branch, reg_dst, mem_to_reg,
//                reg_write, mem_write - datapath enables and selects
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_maindec
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       mem_write
);

  state_t r_state;
  state_t w_next_state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. op is only looked at in DECODE and MEMADR so the
  // instruction register may change freely in every other state.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          c_OP_LW, c_OP_SW: w_next_state = S_MEMADR;
          c_OP_RTYPE:       w_next_state = S_EXECUTE;
          c_OP_BEQ:         w_next_state = S_BEQEX;
          c_OP_ADDI:        w_next_state = S_ADDIEX;
          c_OP_ORI:         w_next_state = S_ORIEX;
          c_OP_J:           w_next_state = S_JEX;
          default:          w_next_state = S_FETCH;
        endcase
      end
      // Anything other than lw reaching here is taken as a store
      S_MEMADR:  w_next_state = (op == c_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next_state = S_MEMWB;
      S_EXECUTE: w_next_state = S_ALUWB;
      S_ADDIEX:  w_next_state = S_IWB;
      S_ORIEX:   w_next_state = S_IWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_IWB, S_BEQEX, S_JEX:
                 w_next_state = S_FETCH;
      // Spare encodings fall back to FETCH
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Output decode (Moore: current state only)
  always_comb begin
    alu_op     = c_ALUOP_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = c_SRCB_REG;
    zero_ext   = 1'b0;
    pc_src     = c_PCSRC_ALU;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = c_SRCB_FOUR;
        alu_op    = c_ALUOP_ADD;
      end
      S_DECODE: begin
        alu_src_b = c_SRCB_IMMSH;
        alu_op    = c_ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = c_SRCB_IMM;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = c_ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = c_ALUOP_SUB;
        pc_src    = c_PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = c_SRCB_IMM;
        alu_op    = c_ALUOP_ADD;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = c_SRCB_IMM;
        zero_ext  = 1'b1;
        alu_op    = c_ALUOP_OR;
      end
      S_IWB: begin
        reg_write = 1'b1;
      end
      S_JEX: begin
        pc_src   = c_PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule : multicycle_maindec
`default_nettype wire
